// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Holds default counter width, default period and channel-index width.
package clk_div_pkg;

  localparam int          DEF_CNT_W = 32;
  localparam int unsigned DEF_DIV   = 100000000;

  // Width of a channel index; never below one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active and pending divisors.
// Ports: clk, rst, en, sync_restart, wr, wr_div -> tick, clkout, pend.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             clkout,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cur_div;
  logic [CNT_W-1:0] pend_div;
  logic             run;
  logic             last;
  logic             apply;

  assign run   = en & ~sync_restart;
  assign last  = (cnt == cur_div - CNT_W'(1));
  // A pending divisor lands only where cnt returns to 0.
  assign apply = pend & (sync_restart | (en & last));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      cur_div  <= CNT_W'(DEFAULT_DIV);
      pend_div <= '0;
      pend     <= 1'b0;
      tick     <= 1'b0;
      clkout   <= 1'b0;
    end else begin
      tick   <= run & last;
      clkout <= run & (cnt >= (cur_div >> 1));

      if (!run || last) cnt <= '0;
      else              cnt <= cnt + CNT_W'(1);

      if (wr && !run) begin
        // Idle or restarting: counter is at 0, safe to switch now.
        cur_div <= wr_div;
        pend    <= 1'b0;
      end else if (wr) begin
        // Older pending value retires first; new one queues behind it.
        if (apply) cur_div <= pend_div;
        pend_div <= wr_div;
        pend     <= 1'b1;
      end else if (apply) begin
        cur_div <= pend_div;
        pend    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_channel_clock_divider.sv
// CHANNELS independent programmable clock dividers with a shared write port.
// Ports: clk, rst, en, sync_restart, cfg_* -> cfg_err, pend, tick, clkout.
module multi_channel_clock_divider
  import clk_div_pkg::*;
#(
  parameter int          CHANNELS    = 4,
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         en,
  input  logic                        sync_restart,
  input  logic                        cfg_we,
  input  logic [ch_w(CHANNELS)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]            cfg_div,
  output logic                        cfg_err,
  output logic [CHANNELS-1:0]         pend,
  output logic [CHANNELS-1:0]         tick,
  output logic [CHANNELS-1:0]         clkout
);

  localparam int CH_W = ch_w(CHANNELS);

  logic cfg_ok;

  assign cfg_ok = (cfg_div != '0) &&
                  (32'(cfg_ch) < 32'(CHANNELS));

  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_we & ~cfg_ok;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr;

    assign wr = cfg_we & cfg_ok & (cfg_ch == CH_W'(i));

    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .en           (en[i]),
      .sync_restart (sync_restart),
      .wr           (wr),
      .wr_div       (cfg_div),
      .tick         (tick[i]),
      .clkout       (clkout[i]),
      .pend         (pend[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Self-checking bench for multi_channel_clock_divider.
// Table vectors, directed corner sequences and a random run vs a model.
module tb_multi_channel_clock_divider;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int DEF = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] en = '0;
  logic           sync_restart = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [CW-1:0]  cfg_div = '0;
  logic           cfg_err;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clkout;

  multi_channel_clock_divider #(
    .CHANNELS    (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sync_restart (sync_restart),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_div      (cfg_div),
    .cfg_err      (cfg_err),
    .pend         (pend),
    .tick         (tick),
    .clkout       (clkout)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: position within the current period, active
  // period, and an optional queued period per channel.
  int       ph  [NCH];
  int       cur [NCH];
  int       pdv [NCH];
  bit       pn  [NCH];
  logic [NCH-1:0] xt, xc, xp;
  logic           xe;

  function automatic void mdl_reset();
    for (int c = 0; c < NCH; c++) begin
      ph[c] = 0; cur[c] = DEF; pdv[c] = 0; pn[c] = 0;
    end
    xt = '0; xc = '0; xp = '0; xe = 1'b0;
  endfunction

  function automatic void mdl_edge(input logic [NCH-1:0] e,
                                   input logic s, input logic w,
                                   input logic [1:0] ch,
                                   input logic [CW-1:0] d);
    bit ok;
    ok = w && (d != 0) && (ch < NCH);
    xe = w && !ok;
    for (int c = 0; c < NCH; c++) begin
      bit runs, ends;
      runs = e[c] && !s;
      ends = runs && (((ph[c] + 1) % cur[c]) == 0);
      xt[c] = ends;
      xc[c] = runs && (ph[c] >= cur[c] / 2);
      ph[c] = runs ? (ph[c] + 1) % cur[c] : 0;
      if ((ends || s) && pn[c]) begin
        cur[c] = pdv[c];
        pn[c]  = 0;
      end
      if (ok && ch == c) begin
        if (!e[c] || s) begin
          cur[c] = d; pn[c] = 0;
        end else begin
          pdv[c] = d; pn[c] = 1;
        end
      end
      xp[c] = pn[c];
    end
  endfunction

  task automatic chk(input string nm, input logic [9:0] got,
                     input logic [9:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b", nm, got, exp);
    end
  endtask

  task automatic apply(input logic [NCH-1:0] e, input logic s,
                       input logic w, input logic [1:0] ch,
                       input logic [CW-1:0] d);
    en = e; sync_restart = s; cfg_we = w; cfg_ch = ch; cfg_div = d;
    @(posedge clk);
    mdl_edge(e, s, w, ch, d);
    #1;
    chk("model", {tick, clkout, pend, cfg_err}, {xt, xc, xp, xe});
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_we = 1'b0; sync_restart = 1'b0;
    @(posedge clk);
    mdl_reset();
    #1;
    chk("reset", {tick, clkout, pend, cfg_err}, 10'd0);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(3'b111, 1'b0, 1'b0, 2'd0, 16'd0);
  endtask

  typedef struct {
    logic [NCH-1:0] e;
    logic           we;
    logic [1:0]     ch;
    logic [CW-1:0]  d;
    logic [NCH-1:0] tk;
    logic [NCH-1:0] ck;
    logic           er;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Default period 8 from reset, all enabled: 4 low, 4 high,
    // tick on the 8th edge; then two rejected writes.
    tbl[0]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 1'b0};
    tbl[1]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 1'b0};
    tbl[2]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 1'b0};
    tbl[3]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 1'b0};
    tbl[4]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b111, 1'b0};
    tbl[5]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b111, 1'b0};
    tbl[6]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b111, 1'b0};
    tbl[7]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b111, 3'b111, 1'b0};
    tbl[8]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 1'b0};
    tbl[9]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 1'b0};
    tbl[10] = '{3'b111, 1'b1, 2'd3, 16'd5, 3'b000, 3'b000, 1'b1};
    tbl[11] = '{3'b111, 1'b1, 2'd0, 16'd0, 3'b000, 3'b000, 1'b1};
    tbl[12] = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b111, 1'b0};

    mdl_reset();
    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].e, 1'b0, tbl[i].we, tbl[i].ch, tbl[i].d);
      chk($sformatf("tbl%0d", i), {tick, clkout, pend, cfg_err},
          {tbl[i].tk, tbl[i].ck, 3'b000, tbl[i].er});
    end
    idle(8);

    // Runtime change on ch1: div 6, then 3 written mid-period.
    apply(3'b101, 1'b0, 1'b0, 2'd0, 16'd0);
    apply(3'b101, 1'b0, 1'b1, 2'd1, 16'd6);
    idle(2);
    apply(3'b111, 1'b0, 1'b1, 2'd1, 16'd3);
    chk("pend1_set", 10'(pend[1]), 10'd1);
    idle(2);
    chk("pend1_hold", 10'(pend[1]), 10'd1);
    idle(1);
    chk("pend1_clr", 10'({pend[1], tick[1]}), 10'b01);
    idle(9);

    // Write to a disabled channel takes effect at once.
    apply(3'b011, 1'b0, 1'b0, 2'd0, 16'd0);
    apply(3'b011, 1'b0, 1'b1, 2'd2, 16'd5);
    chk("pend2_none", 10'(pend[2]), 10'd0);
    idle(5);
    chk("ch2_first5", 10'(tick[2]), 10'd1);
    idle(10);

    // Divisor 1: stuck high while enabled.
    apply(3'b110, 1'b0, 1'b1, 2'd0, 16'd1);
    idle(4);
    chk("div1", 10'({tick[0], clkout[0]}), 10'b11);

    // Write coincident with wrap on ch1 (div 3).
    apply(3'b111, 1'b0, 1'b1, 2'd1, 16'd4);
    for (int k = 0; k < 40 && ph[1] != cur[1] - 1; k++) idle(1);
    if (ph[1] != cur[1] - 1) begin
      nvec++; nerr++;
      $display("FAIL wrap_wait: got ph %0d want %0d", ph[1], cur[1] - 1);
    end
    apply(3'b111, 1'b0, 1'b1, 2'd1, 16'd10);
    chk("coinc_pend", 10'(pend[1]), 10'd1);
    idle(3);
    chk("coinc_mid", 10'({pend[1], tick[1]}), 10'b10);
    idle(1);
    chk("coinc_4", 10'({pend[1], tick[1]}), 10'b01);
    idle(12);

    // sync_restart with ch0=5, ch2=7 at different phases.
    apply(3'b010, 1'b0, 1'b1, 2'd0, 16'd5);
    apply(3'b010, 1'b0, 1'b1, 2'd2, 16'd7);
    for (int k = 0; k < 3; k++) apply(3'b011, 1'b0, 1'b0, 2'd0, 16'd0);
    idle(2);
    apply(3'b111, 1'b1, 1'b0, 2'd0, 16'd0);
    chk("sr_out", {tick, clkout, 4'b0}, 10'd0);
    idle(5);
    chk("sr_tick0", 10'({tick[0], tick[2]}), 10'b10);
    idle(2);
    chk("sr_tick2", 10'({tick[0], tick[2]}), 10'b01);
    idle(3);

    // Reset in mid-period returns to the default period.
    do_reset();
    idle(8);
    chk("rst_def", {tick, 7'b0}, {3'b111, 7'b0});

    // Random run against the model.
    for (int k = 0; k < 600; k++) begin
      logic [NCH-1:0] e;
      e = ($urandom % 4 == 0) ? 3'($urandom) : 3'b111;
      apply(e, 1'($urandom % 30 == 0), 1'($urandom % 4 == 0),
            2'($urandom), 16'($urandom % 10));
      if (k == 300) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multi_channel_clock_divider.md
Name: multi_channel_clock_divider

Overview:
- Parametrised successor of the single fixed-period divider.
- Provides CHANNELS independent dividers of the system clock.
- Each channel's period is programmable at runtime through a write port and has its own enable.
- Each channel produces a near-50% square wave (clkout) and a one-cycle tick strobe, used as a clock enable.
- Period changes take effect only at a period boundary, so outputs never glitch. A global sync_restart phase-aligns all channels.

Parameters:
- CHANNELS, 4, number of divider channels (1..16).
- CNT_W, 32, width of counters and divisor registers.
- DEFAULT_DIV, 100000000, reset-time period in clk cycles for every channel; must be >=1 and <2^CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  CHANNELS  per-channel run enable.
- sync_restart  in  1  one-cycle pulse: restart all channels at phase 0.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  max(1,$clog2(CHANNELS))  target channel.
- cfg_div  in  CNT_W  new period in cycles.
- cfg_err  out  1  registered pulse: write rejected.
- pend  out  CHANNELS  per-channel flag: a divisor write is waiting for a boundary.
- tick  out  CHANNELS  registered one-cycle pulse, once per period.
- clkout  out  CHANNELS  registered divided clock.

Behaviour:
- Reset (rst=1 at a clk edge), for all channels:
  - cnt=0, cur_div=DEFAULT_DIV, pend_div=0.
  - pend=0, tick=0, clkout=0, cfg_err=0.
- Counter, per channel, evaluated at each edge:
  - If en=0 or sync_restart=1: cnt<=0.
  - Else if cnt==cur_div-1: cnt<=0 (wrap).
  - Else: cnt<=cnt+1.
- Outputs are registered from pre-edge values:
  - tick<=en & ~sync_restart & (cnt==cur_div-1).
  - clkout<=en & ~sync_restart & (cnt >= cur_div>>1).
  - Low phase is floor(div/2) cycles; high phase is ceil(div/2) cycles. Odd divisors therefore have the longer phase high.
  - Period is exactly cur_div cycles.
  - From the first edge that samples en=1, the first tick appears after cur_div edges. For example, div=4 gives clkout 0,0,1,1 and tick on the 4th.
- cur_div=1: tick constant 1 and clkout constant 1 while enabled.
- Disabled channel: tick=0 and clkout=0 one cycle after en falls; counter held at 0.
- Divisor write (cfg_we=1):
  - Rejected if cfg_div==0 or cfg_ch>=CHANNELS. Effect: cfg_err=1 for one cycle, no state change.
  - If the target channel has en=0, or sync_restart=1: cur_div<=cfg_div immediately, pend cleared.
  - Otherwise: pend_div<=cfg_div, pend<=1. A later write overwrites pend_div.
- Pending application:
  - On a wrap edge with pend=1: cur_div<=pend_div, pend<=0.
  - On a sync_restart edge with pend=1: same update applies.
- Simultaneous write and wrap on the same channel:
  - The previous pend_div (if pend=1) is applied at that edge.
  - The new cfg_div becomes the pending value; pend stays 1.
  - If pend was 0: cur_div is unchanged and the write becomes pending.
- Invariant: cnt <= cur_div-1 at all times, because cur_div changes only when cnt returns to 0.
- en changes mid-period: falling en discards phase. Rising en starts from cnt=0.
- sync_restart has priority over en-driven counting. Its effect is identical to all enabled channels restarting on the same edge.
- Counter arithmetic is unsigned CNT_W. No overflow is possible, since cur_div<2^CNT_W.

Decomposition:
- Package clk_div_pkg:
  - CNT_W default.
  - Channel-index width function.
  - DEFAULT_DIV constant.
- Sub-module clk_div_channel:
  - Holds one channel's cnt, cur_div, pend_div and pend.
  - Drives that channel's tick and clkout.
  - Inputs: en, sync_restart, wr (decoded strobe), wr_div.
- Top module:
  - Instantiates CHANNELS copies via generate.
  - Decodes cfg_ch and validates the write.
  - Registers cfg_err.

Test Plan:
- Reset defaults, DEFAULT_DIV=8, en=all 1 after reset → every channel: clkout 4 low / 4 high, tick once every 8 cycles, first tick 8 edges after en sampled.
- Runtime change while running: ch1 div=6, write 3 mid-period → pend[1]=1 until the next wrap. Remaining period stays 6; subsequent periods are 3 (clkout 1 low / 2 high). pend clears on the wrap edge.
- Disabled write: en[2]=0, write 5, then en[2]=1 → pend[2] never set; first period is 5 (clkout 2 low / 3 high).
- Boundary divisors: div=1 → tick and clkout stuck 1 while enabled. Write div=0 or cfg_ch=CHANNELS → cfg_err pulses one cycle; divisors unchanged.
- Write coincident with wrap: pend_div=4 pending, write 10 on the wrap edge → next period 4, then 10. pend=1 between those two boundaries.
- sync_restart and mid-operation rst: channels at divs 5 and 7 with arbitrary phases, pulse sync_restart → both clkout=0, ticks coincide 5 and 7 cycles later. Assert rst mid-period → all outputs 0 next edge; cur_div returns to DEFAULT_DIV.
